// File: rtl/mem_access_ctrl.sv
// Sequences CPU memory requests (MEM_EN/WE, MAR/MDR) into timed accesses on an on-chip synchronous RAM.
// Optional macro MMIO_HEX_EN maps MAR=0xFFFF to SW (read) and hex_out (write) instead of RAM.
//
// state  | meaning
// IDLE   | waiting for MEM_EN; latches WE/MAR/MDR and loads the wait counter
// ACCESS | RAM/MMIO cycle in progress, wait counter running down to zero
// DONE   | R pulses for this single cycle
// HOLD   | waiting for MEM_EN to drop before accepting another request
module mem_access_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_EN,
  input  logic              WE,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  output logic [15:0]       Data_to_CPU,
  output logic              R,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       SW,
  output logic [15:0]       hex_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        acc_we;
  logic        acc_ram;
  logic        acc_mmio;
  logic        addr_mmio;
  logic        addr_ram;
  logic        capture;
  logic [15:0] sw_val;

`ifdef MMIO_HEX_EN
  assign addr_mmio = (MAR == 16'hFFFF);
  assign sw_val    = SW;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_out <= 16'h0000;
    end else if (capture && acc_we && acc_mmio) begin
      hex_out <= mem_wdata;
    end
  end
`else
  logic unused_sw;

  assign addr_mmio = 1'b0;
  assign sw_val    = 16'h0000;
  assign hex_out   = 16'h0000;
  assign unused_sw = ^SW;
`endif

  // Anything with a MAR bit at or above ADDR_W never reaches the RAM.
  assign addr_ram = ((MAR >> ADDR_W) == 16'h0000) && !addr_mmio;
  assign capture  = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      acc_we      <= 1'b0;
      acc_ram     <= 1'b0;
      acc_mmio    <= 1'b0;
      Data_to_CPU <= 16'h0000;
      R           <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 16'h0000;
      mem_ce      <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      R      <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (MEM_EN) begin
            acc_we    <= WE;
            acc_ram   <= addr_ram;
            acc_mmio  <= addr_mmio;
            mem_addr  <= MAR[ADDR_W-1:0];
            mem_wdata <= MDR;
            cnt       <= CNT_LOAD;
            mem_ce    <= addr_ram;
            mem_we    <= WE && addr_ram;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!acc_we) begin
              if (acc_ram)       Data_to_CPU <= mem_rdata;
              else if (acc_mmio) Data_to_CPU <= sw_val;
              else               Data_to_CPU <= 16'h0000;
            end
            mem_ce <= 1'b0;
            R      <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          if (!MEM_EN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
